vm_msg_ctrl: RTL and testbench
==============================

VM_MSG_CTRL -- requirements
Module: vm_msg_ctrl

Interface
REQ-001 Parameter: NSLOTS, 8, number of message slots; power of two.
REQ-002 Parameter: SLOT_DEPTH, 256, samples per slot; power of two.
REQ-003 Parameter: DW, 8, sample width in bits.
REQ-004 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  in  1  reset, synchronous and active-high.
REQ-006 Port: play, erase, save  in  1 each  single-cycle command strobes from the voice-mail sequencer.
REQ-007 Port: recrd  in  1  level; high while recording is requested.
REQ-008 Port: samp_in, samp_in_vld  in  DW, 1  codec capture sample and its qualifier.
REQ-009 Port: samp_out_rdy  in  1  codec ready to accept a playback sample.
REQ-010 Port: samp_out, samp_out_vld  out  DW, 1  playback sample and its qualifier.
REQ-011 Port: mem_addr  out  log2(NSLOTS)+log2(SLOT_DEPTH)  {slot, offset}.
REQ-012 Port: mem_we, mem_re, mem_wdata  out  1, 1, DW  external sample RAM write, read, and write data.
REQ-013 Port: mem_rdata  in  DW  RAM read data, valid one cycle after mem_re.
REQ-014 Port: busy, full, empty  out  1 each  activity and slot-occupancy status.
REQ-015 Port: msg_count  out  log2(NSLOTS)+1  number of valid slots.

Function
REQ-016 The block SHALL keep, per slot, a valid bit, a saved bit and a length (0..SLOT_DEPTH), plus a cursor slot index.
REQ-017 The state machine SHALL have exactly three states: IDLE, REC and PLAY; busy=1 outside IDLE.
REQ-018 In IDLE, simultaneous commands SHALL be taken with priority erase > save > play > recrd rising edge; the others SHALL be dropped.
REQ-019 On a recrd rising edge in IDLE, the block SHALL allocate the lowest-index invalid slot, set offset=0 and enter REC; if no slot is free, it SHALL stay in IDLE (see REQ-033).
REQ-020 In REC, each cycle with samp_in_vld=1 SHALL produce mem_we=1, mem_addr={slot,offset} and mem_wdata=samp_in in the same cycle, then offset+1.
REQ-021 REC SHALL end when recrd is low or offset reaches SLOT_DEPTH; the slot SHALL then get valid=1, saved=0 and length=offset, the cursor SHALL move to that slot, and the state SHALL return to IDLE. A sample arriving in the cycle recrd falls SHALL be dropped.
REQ-022 A recording of length 0 SHALL leave the slot invalid.
REQ-023 A play strobe in IDLE with the cursor slot valid SHALL enter PLAY at offset 0; with the cursor slot invalid it SHALL be a no-op.
REQ-024 In PLAY, each cycle with samp_out_rdy=1 and offset<length SHALL produce mem_re=1 and offset+1; samp_out=mem_rdata with samp_out_vld=1 SHALL follow exactly one cycle later.
REQ-025 PLAY SHALL return to IDLE in the cycle after the last samp_out_vld.
REQ-026 An erase strobe SHALL clear valid and saved on the cursor slot, then advance the cursor to the next valid slot, wrapping modulo NSLOTS; if none is valid, the cursor SHALL be unchanged.
REQ-027 A save strobe SHALL set saved on a valid cursor slot, then advance the cursor as in REQ-026.
REQ-028 play, erase and save SHALL be ignored outside IDLE.
REQ-029 msg_count, full (=NSLOTS) and empty (=0) SHALL be registered and update the cycle after any valid-bit change.

Reset
REQ-030 When rst=1, the block SHALL enter IDLE and clear all valid, saved and length fields, cursor and offset.
REQ-031 During reset, all outputs SHALL be 0 except empty=1.
REQ-032 Reset during REC or PLAY SHALL discard the partial operation; no slot SHALL become valid.

Configuration
REQ-033 Macro VM_OVERWRITE_EN: when defined, a recrd rising edge with full=1 SHALL reuse the lowest-index slot with saved=0; if every slot is saved, the recording SHALL be refused. When undefined, a recrd rising edge with full=1 SHALL always be refused and the block SHALL stay in IDLE.

Structure
REQ-034 Shared package vm_pkg SHALL hold the state enumeration, default NSLOTS, SLOT_DEPTH and DW, and the slot-descriptor record type.
REQ-035 The slot table (valid, saved, length, free-slot and next-valid search) SHALL be a sub-module vm_slot_table; the sequencing FSM SHALL stay in vm_msg_ctrl.

Verification
REQ-036 After reset, recrd held high for 5 samp_in_vld cycles (0x11..0x15), then low -> writes at addresses 0..4; msg_count=1, slot0 length=5.
REQ-037 play with samp_out_rdy=1 constantly -> 5 consecutive mem_re pulses; samp_out=0x11..0x15 with a 1-cycle lag; busy low one cycle after the last sample.
REQ-038 Fill all 8 slots, then assert recrd -> without VM_OVERWRITE_EN: no mem_we, full=1. With the macro and only slot2 unsaved: recording goes into slot2.
REQ-039 Record 300 samples with SLOT_DEPTH=256 -> exactly 256 writes, length=256, IDLE while recrd is still high.
REQ-040 Slots 0 and 3 valid with cursor=0; an erase strobe -> slot0 invalid, cursor=3, msg_count=1.
REQ-041 rst asserted mid-REC after 3 samples -> slot not valid, msg_count=0, empty=1.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and default sizing for the voice-mail message controller.
package vm_pkg;

    localparam int VM_NSLOTS     = 8;
    localparam int VM_SLOT_DEPTH = 256;
    localparam int VM_DW         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } vm_state_e;

    // Per-slot flags; the length lives beside it since its width follows SLOT_DEPTH.
    typedef struct packed {
        logic valid;
        logic saved;
    } slot_desc_t;

endpackage

// File: rtl/vm_slot_table.sv
// Slot descriptors, lengths, cursor and occupancy status with free/next-valid search.
// VM_OVERWRITE_EN: when the table is full, allocate the lowest unsaved slot instead.
module vm_slot_table
    import vm_pkg::*;
#(
    parameter int NSLOTS     = VM_NSLOTS,
    parameter int SLOT_DEPTH = VM_SLOT_DEPTH,
    localparam int SW = $clog2(NSLOTS),
    localparam int LW = $clog2(SLOT_DEPTH) + 1,
    localparam int CW = SW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commit,
    input  logic [SW-1:0] commit_slot,
    input  logic [LW-1:0] commit_len,
    input  logic          erase,
    input  logic          save,
    output logic          alloc_vld,
    output logic [SW-1:0] alloc_slot,
    output logic [SW-1:0] cursor,
    output logic          cur_valid,
    output logic [LW-1:0] cur_len,
    output logic [CW-1:0] msg_count,
    output logic          full,
    output logic          empty
);

    slot_desc_t    desc_q [NSLOTS];
    logic [LW-1:0] len_q  [NSLOTS];
    logic [SW-1:0] cursor_q;
    logic          free_vld;
    logic [SW-1:0] free_slot;
    logic          next_vld;
    logic [SW-1:0] next_slot;
    logic [SW-1:0] scan_idx;
    logic [CW-1:0] count_c;
`ifdef VM_OVERWRITE_EN
    logic          reuse_vld;
    logic [SW-1:0] reuse_slot;
`endif

    always_comb begin
        free_vld  = 1'b0;
        free_slot = '0;
        next_vld  = 1'b0;
        next_slot = cursor_q;
        scan_idx  = '0;
        count_c   = '0;
        // Descending scans so the lowest matching index is the one that sticks.
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (!desc_q[i].valid) begin
                free_vld  = 1'b1;
                free_slot = SW'(i);
            end
            count_c = count_c + CW'(desc_q[i].valid);
        end
        for (int i = NSLOTS - 1; i >= 1; i--) begin
            scan_idx = cursor_q + SW'(i);
            if (desc_q[scan_idx].valid) begin
                next_vld  = 1'b1;
                next_slot = scan_idx;
            end
        end
`ifdef VM_OVERWRITE_EN
        reuse_vld  = 1'b0;
        reuse_slot = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (desc_q[i].valid && !desc_q[i].saved) begin
                reuse_vld  = 1'b1;
                reuse_slot = SW'(i);
            end
        end
        alloc_vld  = free_vld | reuse_vld;
        alloc_slot = free_vld ? free_slot : reuse_slot;
`else
        alloc_vld  = free_vld;
        alloc_slot = free_slot;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOTS; i++) begin
                desc_q[i] <= '0;
                len_q[i]  <= '0;
            end
            cursor_q  <= '0;
            msg_count <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            msg_count <= count_c;
            full      <= (count_c == CW'(NSLOTS));
            empty     <= (count_c == '0);
            // A zero-length recording leaves the slot (and any old message in it) untouched.
            if (commit && commit_len != '0) begin
                desc_q[commit_slot] <= '{valid: 1'b1, saved: 1'b0};
                len_q[commit_slot]  <= commit_len;
                cursor_q            <= commit_slot;
            end else if (erase) begin
                desc_q[cursor_q] <= '0;
                if (next_vld) cursor_q <= next_slot;
            end else if (save) begin
                if (desc_q[cursor_q].valid) desc_q[cursor_q].saved <= 1'b1;
                if (next_vld) cursor_q <= next_slot;
            end
        end
    end

    assign cursor    = cursor_q;
    assign cur_valid = desc_q[cursor_q].valid;
    assign cur_len   = len_q[cursor_q];

endmodule

// File: rtl/vm_msg_ctrl.sv
// Voice-mail message controller: record/play sequencing over an external sample RAM.
// VM_OVERWRITE_EN (passed to vm_slot_table): recording into a full table reuses an unsaved slot.
module vm_msg_ctrl
    import vm_pkg::*;
#(
    parameter int NSLOTS     = VM_NSLOTS,
    parameter int SLOT_DEPTH = VM_SLOT_DEPTH,
    parameter int DW         = VM_DW,
    localparam int SW = $clog2(NSLOTS),
    localparam int OW = $clog2(SLOT_DEPTH),
    localparam int LW = OW + 1,
    localparam int AW = SW + OW,
    localparam int CW = SW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          play,
    input  logic          erase,
    input  logic          save,
    input  logic          recrd,
    input  logic [DW-1:0] samp_in,
    input  logic          samp_in_vld,
    input  logic          samp_out_rdy,
    output logic [DW-1:0] samp_out,
    output logic          samp_out_vld,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] msg_count
);

    vm_state_e     state_q, state_d;
    logic [LW-1:0] offset_q, offset_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          recrd_q;
    logic          vld_p1;
    logic          rec_rise;
    logic          we_c, re_c, commit_c, erase_c, save_c;
    logic          alloc_vld;
    logic [SW-1:0] alloc_slot;
    logic [SW-1:0] cursor;
    logic          cur_valid;
    logic [LW-1:0] cur_len;

    vm_slot_table #(
        .NSLOTS     (NSLOTS),
        .SLOT_DEPTH (SLOT_DEPTH)
    ) u_tab (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit_c),
        .commit_slot (slot_q),
        .commit_len  (offset_q),
        .erase       (erase_c),
        .save        (save_c),
        .alloc_vld   (alloc_vld),
        .alloc_slot  (alloc_slot),
        .cursor      (cursor),
        .cur_valid   (cur_valid),
        .cur_len     (cur_len),
        .msg_count   (msg_count),
        .full        (full),
        .empty       (empty)
    );

    assign rec_rise = recrd & ~recrd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            offset_q <= '0;
            slot_q   <= '0;
            recrd_q  <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            slot_q   <= slot_d;
            recrd_q  <= recrd;
            vld_p1   <= re_c;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        slot_d   = slot_q;
        we_c     = 1'b0;
        re_c     = 1'b0;
        commit_c = 1'b0;
        erase_c  = 1'b0;
        save_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (erase) begin
                    erase_c = 1'b1;
                end else if (save) begin
                    save_c = 1'b1;
                end else if (play) begin
                    if (cur_valid) begin
                        state_d  = ST_PLAY;
                        offset_d = '0;
                        slot_d   = cursor;
                    end
                end else if (rec_rise && alloc_vld) begin
                    state_d  = ST_REC;
                    offset_d = '0;
                    slot_d   = alloc_slot;
                end
            end
            ST_REC: begin
                // The sample in the cycle recrd drops is not written.
                if (!recrd || offset_q == LW'(SLOT_DEPTH)) begin
                    commit_c = 1'b1;
                    state_d  = ST_IDLE;
                end else if (samp_in_vld) begin
                    we_c     = 1'b1;
                    offset_d = offset_q + LW'(1);
                end
            end
            ST_PLAY: begin
                if (samp_out_rdy && offset_q < cur_len) begin
                    re_c     = 1'b1;
                    offset_d = offset_q + LW'(1);
                end else if (offset_q == cur_len && vld_p1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is held, before the first reset edge lands.
    assign mem_we       = we_c & ~rst;
    assign mem_re       = re_c & ~rst;
    assign mem_addr     = (mem_we | mem_re) ? {slot_q, offset_q[OW-1:0]} : '0;
    assign mem_wdata    = mem_we ? samp_in : '0;
    assign samp_out_vld = vld_p1 & ~rst;
    assign samp_out     = samp_out_vld ? mem_rdata : '0;
    assign busy         = (state_q != ST_IDLE) & ~rst;

endmodule

// File: tb/tb_vm_msg_ctrl.sv
// Self-checking bench for vm_msg_ctrl against a slot-level behavioural model.
module tb_vm_msg_ctrl;

    localparam int NS = 8;
    localparam int SD = 256;
    localparam int DW = 8;
    localparam int AW = 11;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, play, erase, save, recrd, samp_in_vld, samp_out_rdy;
    logic [DW-1:0] samp_in, samp_out, mem_wdata, mem_rdata;
    logic          samp_out_vld, mem_we, mem_re, busy, full, empty;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] msg_count;

    always #5 clk = ~clk;

    vm_msg_ctrl #(.NSLOTS(NS), .SLOT_DEPTH(SD), .DW(DW)) dut (
        .clk(clk), .rst(rst), .play(play), .erase(erase), .save(save), .recrd(recrd),
        .samp_in(samp_in), .samp_in_vld(samp_in_vld), .samp_out_rdy(samp_out_rdy),
        .samp_out(samp_out), .samp_out_vld(samp_out_vld), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .full(full), .empty(empty), .msg_count(msg_count)
    );

    // External sample RAM
    logic [DW-1:0] ram [NS*SD];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Bus monitor
    logic [AW+DW-1:0] wq[$];
    logic [DW-1:0]    oq[$];
    int re_cyc[$];
    int vld_cyc[$];
    int cyc = 0;
    int busy_fall = -1;
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        if (mem_re) re_cyc.push_back(cyc);
        if (samp_out_vld) begin
            oq.push_back(samp_out);
            vld_cyc.push_back(cyc);
        end
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
        cyc++;
    end

    // Reference model: one entry per message slot plus the cursor
    bit            m_valid [NS];
    bit            m_saved [NS];
    int            m_len   [NS];
    logic [DW-1:0] m_data  [NS][SD];
    int            m_cursor;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NS; i++) c += m_valid[i];
        return c;
    endfunction

    function automatic int m_alloc();
        for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
`ifdef VM_OVERWRITE_EN
        for (int i = 0; i < NS; i++) if (!m_saved[i]) return i;
`endif
        return -1;
    endfunction

    function automatic void m_advance();
        for (int i = 1; i < NS; i++) begin
            if (m_valid[(m_cursor + i) % NS]) begin
                m_cursor = (m_cursor + i) % NS;
                return;
            end
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0;
            m_saved[i] = 0;
            m_len[i]   = 0;
        end
        m_cursor = 0;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_msg_count"}, 32'(msg_count), m_count());
        chk({tag, "_full"}, 32'(full), 32'(m_count() == NS));
        chk({tag, "_empty"}, 32'(empty), 32'(m_count() == 0));
    endtask

    // Record n samples (base<0: random data); an erase strobe lands inside REC and must be ignored.
    task automatic do_record(input int n, input bit gaps, input int base);
        int slot, wr, bad;
        logic [DW-1:0] s[$];
        slot = m_alloc();
        wq.delete();
        recrd = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                samp_in_vld = 1'b0;
                repeat ($urandom_range(0, 1)) tick();
            end
            samp_in     = (base >= 0) ? DW'(base + k) : DW'($urandom);
            samp_in_vld = 1'b1;
            erase       = (slot >= 0 && k == 1);
            s.push_back(samp_in);
            tick();
            erase = 1'b0;
        end
        samp_in_vld = 1'b0;
        if (slot >= 0 && n > SD) chk("idle_recrd_high", 32'(busy), 0);
        recrd = 1'b0;
        repeat (3) tick();
        wr = (slot < 0) ? 0 : ((n > SD) ? SD : n);
        chk("wr_count", wq.size(), wr);
        bad = 0;
        for (int k = 0; k < wr && k < wq.size(); k++)
            if (wq[k] !== {AW'(slot * SD + k), s[k]}) bad++;
        chk("wr_content", bad, 0);
        if (wr > 0) begin
            m_valid[slot] = 1;
            m_saved[slot] = 0;
            m_len[slot]   = wr;
            for (int k = 0; k < wr; k++) m_data[slot][k] = s[k];
            m_cursor = slot;
        end
        check_status("rec");
    endtask

    // Play the cursor message; a save strobe inside PLAY must be ignored.
    task automatic do_play(input bit gaps);
        int exp_n, bad;
        oq.delete();
        re_cyc.delete();
        vld_cyc.delete();
        busy_fall = -1;
        exp_n = m_valid[m_cursor] ? m_len[m_cursor] : 0;
        play = 1'b1;
        tick();
        play = 1'b0;
        for (int k = 0; k < 3000 && busy; k++) begin
            save         = (k == 0) ? (exp_n > 0) : 1'b0;
            samp_out_rdy = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        save = 1'b0;
        chk("play_done", 32'(busy), 0);
        samp_out_rdy = 1'b0;
        tick();
        chk("play_re_count", re_cyc.size(), exp_n);
        chk("play_out_count", oq.size(), exp_n);
        bad = 0;
        for (int k = 0; k < exp_n && k < oq.size(); k++)
            if (oq[k] !== m_data[m_cursor][k]) bad++;
        chk("play_data", bad, 0);
        check_status("play");
    endtask

    task automatic do_erase();
        erase = 1'b1;
        tick();
        erase = 1'b0;
        repeat (2) tick();
        m_valid[m_cursor] = 0;
        m_saved[m_cursor] = 0;
        m_advance();
        check_status("erase");
    endtask

    task automatic do_save();
        save = 1'b1;
        tick();
        save = 1'b0;
        repeat (2) tick();
        if (m_valid[m_cursor]) m_saved[m_cursor] = 1;
        m_advance();
        check_status("save");
    endtask

    // All four commands at once: only the erase may take effect.
    task automatic do_combo();
        wq.delete();
        play = 1'b1; erase = 1'b1; save = 1'b1; recrd = 1'b1;
        tick();
        play = 1'b0; erase = 1'b0; save = 1'b0;
        tick();
        recrd = 1'b0;
        repeat (3) tick();
        m_valid[m_cursor] = 0;
        m_saved[m_cursor] = 0;
        m_advance();
        chk("combo_no_write", wq.size(), 0);
        chk("combo_busy", 32'(busy), 0);
        check_status("combo");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; play = 1'b0; erase = 1'b0; save = 1'b0; recrd = 1'b1;
        samp_in = 8'hAA; samp_in_vld = 1'b1; samp_out_rdy = 1'b1;
        m_reset();
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_samp_out_vld", 32'(samp_out_vld), 0);
        chk("rst_samp_out", 32'(samp_out), 0);
        chk("rst_msg_count", 32'(msg_count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        recrd = 1'b0; samp_in_vld = 1'b0; samp_out_rdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Five-sample recording into slot 0
        do_record(5, 1'b0, 8'h11);
        for (int k = 0; k < 5; k++) chk("req036_write", 32'(wq[k]), {13'd0, AW'(k), DW'(8'h11 + k)});
        chk("req036_count", 32'(msg_count), 1);

        // Playback timing of that message
        do_play(1'b0);
        chk("req037_re_span", re_cyc[4] - re_cyc[0], 4);
        chk("req037_first_lag", vld_cyc[0] - re_cyc[0], 1);
        chk("req037_last_lag", vld_cyc[4] - re_cyc[4], 1);
        chk("req037_busy_fall", busy_fall - vld_cyc[4], 1);
        for (int k = 0; k < 5; k++) chk("req037_sample", 32'(oq[k]), 32'(8'h11 + k));

        // Overlong recording truncates at the slot depth
        do_record(300, 1'b0, -1);
        chk("req039_len", m_len[1], 256);
        do_play(1'b1);

        // Build slots 0 and 3 valid with cursor 0, then erase
        do_record(3, 1'b1, -1);
        do_record(4, 1'b1, -1);
        do_save();
        do_erase();
        do_erase();
        do_erase();
        do_record(6, 1'b0, -1);
        chk("req040_cursor_model", m_cursor, 0);
        do_erase();
        chk("req040_count", 32'(msg_count), 1);
        chk("req040_cursor_model", m_cursor, 3);
        do_play(1'b0);
        chk("req040_play_len", re_cyc.size(), 4);

        // Reset in the middle of a recording
        wq.delete();
        recrd = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            samp_in = DW'(8'h40 + k);
            samp_in_vld = 1'b1;
            tick();
        end
        samp_in_vld = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        recrd = 1'b0;
        m_reset();
        repeat (2) tick();
        chk("req041_writes", wq.size(), 3);
        chk("req041_count", 32'(msg_count), 0);
        chk("req041_empty", 32'(empty), 1);
        do_play(1'b0);

        // Fill every slot, leave only slot 2 unsaved, then record again
        for (int i = 0; i < NS; i++) do_record(2 + i, 1'b0, -1);
        chk("req038_full", 32'(full), 1);
        do_save();
        do_save();
        do_save();
        do_erase();
        for (int i = 0; i < 4; i++) do_save();
        do_record(3, 1'b0, -1);
        chk("req038_full_again", 32'(full), 1);
        do_record(4, 1'b0, 8'h70);
`ifdef VM_OVERWRITE_EN
        chk("req038_reuse_addr", 32'(wq[0][AW+DW-1:DW]), 2 * SD);
`else
        chk("req038_refused", wq.size(), 0);
`endif
        chk("req038_busy", 32'(busy), 0);
        chk("req038_full_end", 32'(full), 1);

        do_record(0, 1'b0, -1);
        do_combo();

        // Randomised mix of operations
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0, 1: do_record($urandom_range(0, 12), 1'($urandom_range(0, 1)), -1);
                2:    do_play(1'($urandom_range(0, 1)));
                3:    do_erase();
                4:    do_save();
                default: do_combo();
            endcase
        end
        do_play(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
